// File: rtl/neuron_config_sequencer.sv
// rtl/neuron_config_sequencer.sv - registered controller that resets and serially programs one neuron per command
module neuron_config_sequencer #(
    parameter int NEURONS = 24,
    parameter int MEMORY  = 8,
    parameter int IDXW    = 5,
    parameter int SETTLE  = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [IDXW-1:0]    CMD_IDX,
    input  logic [MEMORY-1:0]  CMD_DATA,
    input  logic               CMD_CLEAR,
    input  logic               ABORT,
    output logic [NEURONS-1:0] NEURON_RST,
    output logic               CONTROL,
    output logic [NEURONS-1:0] CFG_SEL,
    output logic               CFG_BIT,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR
);

    localparam int CW = $clog2(MEMORY + SETTLE + 1);
    localparam logic [CW-1:0]   SHIFT_LAST  = CW'(MEMORY - 1);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [IDXW:0]   IDX_LIMIT   = (IDXW + 1)'(NEURONS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_SETTLE,
        S_ABORTING,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [IDXW-1:0]   idx_q;
    logic [IDXW-1:0]   idx_nxt;
    logic [MEMORY-1:0] data_q;
    logic              clear_q;
    logic              accept;
    logic              bad_cmd;

    function automatic logic [NEURONS-1:0] onehot(input logic [IDXW-1:0] i);
        onehot = NEURONS'(1) << i;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = CMD_VALID && CMD_READY && (state == S_IDLE);
        bad_cmd   = accept && ({1'b0, CMD_IDX} >= IDX_LIMIT);
        idx_nxt   = (accept && !bad_cmd) ? CMD_IDX : idx_q;
        case (state)
            S_IDLE: begin
                if (accept && !bad_cmd) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_nxt = '0;
                if (ABORT) begin
                    state_nxt = S_ABORTING;
                end else if (clear_q) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ABORT) begin
                    state_nxt = S_ABORTING;
                end else if (cnt == SHIFT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (SETTLE == 0) ? S_DONE : S_SETTLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_SETTLE: begin
                if (ABORT) begin
                    state_nxt = S_ABORTING;
                end else if (cnt == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_ABORTING: state_nxt = S_IDLE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            clear_q    <= 1'b0;
            CMD_READY  <= 1'b0;
            NEURON_RST <= '0;
            CONTROL    <= 1'b0;
            CFG_SEL    <= '0;
            CFG_BIT    <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx_q <= idx_nxt;
            if (accept && !bad_cmd) begin
                data_q  <= CMD_DATA;
                clear_q <= CMD_CLEAR;
            end else if (state_nxt == S_SHIFT) begin
                data_q <= data_q << 1;
            end
            CMD_READY  <= (state_nxt == S_IDLE);
            NEURON_RST <= (state_nxt == S_CLEAR || state_nxt == S_ABORTING) ? onehot(idx_nxt) : '0;
            CONTROL    <= (state_nxt == S_SHIFT);
            CFG_SEL    <= (state_nxt == S_SHIFT || state_nxt == S_SETTLE) ? onehot(idx_nxt) : '0;
            // MSB of the working copy is the bit for the shift cycle being entered.
            CFG_BIT    <= (state_nxt == S_SHIFT) && data_q[MEMORY-1];
            BUSY       <= (state_nxt != S_IDLE);
            DONE       <= (state_nxt == S_DONE);
            ERR        <= bad_cmd || (state_nxt == S_ABORTING);
        end
    end

endmodule
